truth_table_sweeper: RTL and testbench
======================================

// Module: truth_table_sweeper
// PURPOSE
//  Exhaustive, self-timed equivalence checker for small combinational blocks (e.g. De Morgan pairs).
//  - Drives every input combination 0..2^N_IN-1 onto vec_out, in order.
//  - Compares a reference implementation's outputs against a DUT implementation's outputs.
//  - Counts mismatching vectors, records the first failing vector, and reports pass/fail.
//  - Replaces hand-written per-vector truth-table benches with one reusable sequential block.
// PARAMETERS
//  N_IN    2  input vector width; sweep length = 2^N_IN vectors (legal 1..16)
//  N_OUT   1  width of compared output buses
//  SETTLE  1  wait cycles after applying a vector before sampling (legal 0..255)
//  CNT_W   8  mismatch counter width; counter saturates at 2^CNT_W-1
// PORTS
//  clk             in   1      rising-edge clock
//  reset_n         in   1      asynchronous, active-low reset
//  start           in   1      level; sampled in IDLE or DONE, starts a new sweep
//  vec_out         out  N_IN   current stimulus vector; bit N_IN-1 = first operand (A), MSB
//  ref_in          in   N_OUT  reference implementation outputs for vec_out
//  dut_in          in   N_OUT  implementation-under-check outputs for vec_out
//  busy            out  1      sweep in progress
//  done            out  1      sweep complete; held until next start or reset
//  pass            out  1      done and zero mismatches
//  mismatch_cnt    out  CNT_W  number of vectors with ref_in != dut_in, saturating
//  first_fail_vec  out  N_IN   vec_out value of the first mismatch
//  first_fail_vld  out  1      first_fail_vec holds a valid value
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE; all outputs 0; wait counter 0.
//  FSM states:
//  - IDLE: busy=0, done=0.
//  - WAIT: busy=1; counts SETTLE cycles.
//  - CMP: busy=1; one sample cycle per vector.
//  - DONE: busy=0, done=1.
//  IDLE/DONE + start=1 at edge:
//  - vec_out<=0, busy<=1, done<=0, pass<=0, mismatch_cnt<=0, first_fail_vld<=0, first_fail_vec<=0.
//  - Next state = WAIT (wait cnt<=SETTLE-1) if SETTLE>0; CMP if SETTLE==0.
//  WAIT: decrements; leaves for CMP at the edge where the count is 0. Exactly SETTLE cycles.
//  CMP: ref_in/dut_in are sampled at the edge ending this cycle.
//  - Mismatch (any bit differs): mismatch_cnt+1 unless all-ones.
//    If first_fail_vld=0: first_fail_vec<=vec_out, first_fail_vld<=1.
//  - vec_out != all-ones: vec_out<=vec_out+1; next = WAIT (SETTLE>0) or CMP (SETTLE==0).
//  - vec_out == all-ones: no wrap; vec_out holds; busy<=0, done<=1, pass<=(final count==0);
//    next = DONE. Final count includes this vector's result.
//  Latency: done rises exactly 2^N_IN*(SETTLE+1) cycles after the start edge.
//  start while busy: ignored, no restart.
//  start held high in DONE: immediate restart, done drops for the new sweep.
//  Reset mid-sweep: abort, all outputs to reset values, no partial result retained.
//  Combinational paths: none from ref_in/dut_in to outputs; all outputs registered.
//  ref_in/dut_in must be stable within SETTLE cycles of a vec_out change; the block does not check this.
// TESTING
//  T1 N_IN=2,SETTLE=1, ref=~(A|B), dut=~A&~B, pulse start
//     -> done 8 cycles later, pass=1, cnt=0, first_fail_vld=0, vec_out=2'b11.
//  T2 same, dut=~(A&B)
//     -> mismatches at 01,10; cnt=2, first_fail_vec=2'b01, first_fail_vld=1, pass=0.
//  T3 N_IN=3,CNT_W=2, dut=~ref
//     -> cnt saturates at 3, first_fail_vec=0, done after 16 cycles, pass=0.
//  T4 SETTLE=0,N_IN=2, equivalent pair -> vec_out steps 0,1,2,3 on consecutive cycles; done 4 cycles after start.
//  T5 reset_n=0 asynchronously mid-sweep (vec_out=2) -> all outputs 0 immediately;
//     re-start -> full sweep from 0 with fresh count.
//  T6 start pulsed while busy -> no effect on timing;
//     start in DONE -> done=0, cnt cleared next cycle, new sweep completes correctly.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: exhaustive self-timed sweep comparing a reference block against an implementation.
module truth_table_sweeper #(
    parameter int N_IN   = 2,
    parameter int N_OUT  = 1,
    parameter int SETTLE = 1,
    parameter int CNT_W  = 8
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             start_i,
    output logic [N_IN-1:0]  vec_o,
    input  logic [N_OUT-1:0] ref_i,
    input  logic [N_OUT-1:0] dut_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [CNT_W-1:0] mismatch_cnt_o,
    output logic [N_IN-1:0]  first_fail_vec_o,
    output logic             first_fail_vld_o
);
    typedef enum logic [1:0] {IDLE, WAIT, CMP, DONE} state_e;
    localparam logic [7:0] WAIT_INIT = (SETTLE == 0) ? 8'd0 : 8'(SETTLE - 1);
    localparam state_e AFTER_VEC = (SETTLE > 0) ? WAIT : CMP;
    state_e           state_q, state_d;
    logic [N_IN-1:0]  vec_q, vec_d, ffv_q, ffv_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [7:0]       wait_q, wait_d;
    logic             vld_q, vld_d, pass_q, pass_d, mis;
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            vec_q   <= '0;
            ffv_q   <= '0;
            cnt_q   <= '0;
            wait_q  <= '0;
            vld_q   <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            ffv_q   <= ffv_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
            vld_q   <= vld_d;
            pass_q  <= pass_d;
        end
    end
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        ffv_d   = ffv_q;
        cnt_d   = cnt_q;
        wait_d  = wait_q;
        vld_d   = vld_q;
        pass_d  = pass_q;
        mis     = ref_i != dut_i;
        cnt_inc = (mis && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d = AFTER_VEC;
                    vec_d   = '0;
                    ffv_d   = '0;
                    cnt_d   = '0;
                    vld_d   = 1'b0;
                    pass_d  = 1'b0;
                    wait_d  = WAIT_INIT;
                end
            end
            WAIT: begin
                if (wait_q == '0) state_d = CMP;
                else wait_d = wait_q - 1'b1;
            end
            default: begin
                cnt_d = cnt_inc;
                if (mis && !vld_q) begin
                    ffv_d = vec_q;
                    vld_d = 1'b1;
                end
                // Last vector: hold vec_o at all-ones rather than wrapping.
                if (vec_q == '1) begin
                    state_d = DONE;
                    pass_d  = cnt_inc == '0;
                end else begin
                    state_d = AFTER_VEC;
                    vec_d   = vec_q + 1'b1;
                    wait_d  = WAIT_INIT;
                end
            end
        endcase
    end
    always_comb begin
        vec_o            = vec_q;
        busy_o           = state_q == WAIT || state_q == CMP;
        done_o           = state_q == DONE;
        pass_o           = pass_q;
        mismatch_cnt_o   = cnt_q;
        first_fail_vec_o = ffv_q;
        first_fail_vld_o = vld_q;
    end
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: directed checks of the sweeper across three parameter sets.
module tb_truth_table_sweeper;
    logic clk = 1'b0, reset_n = 1'b0, start = 1'b0;
    int   sel = 0, mode = 0, n_chk = 0, n_fail = 0, lat = 0;
    logic [1:0] vec_a, ffv_a, vec_c, ffv_c;
    logic [2:0] vec_b, ffv_b;
    logic [7:0] cnt_a, cnt_c;
    logic [1:0] cnt_b;
    logic busy_a, done_a, pass_a, vld_a, busy_b, done_b, pass_b, vld_b, busy_c, done_c, pass_c, vld_c;
    logic ref_a, dut_a, ref_b, dut_b, ref_c, dut_c;
    logic [31:0] vec_m, ffv_m, cnt_m;
    logic busy_m, done_m, pass_m, vld_m;
    always #5 clk = ~clk;
    // A = vec[MSB], B = vec[LSB]
    assign ref_a = ~(vec_a[1] | vec_a[0]);
    assign dut_a = (mode == 0) ? (~vec_a[1] & ~vec_a[0]) : ~(vec_a[1] & vec_a[0]);
    assign ref_b = ^vec_b;
    assign dut_b = ~ref_b;
    assign ref_c = ~(vec_c[1] & vec_c[0]);
    assign dut_c = ~vec_c[1] | ~vec_c[0];
    truth_table_sweeper #(.N_IN(2), .N_OUT(1), .SETTLE(1), .CNT_W(8)) u_a (
        .clk_i(clk), .reset_n_i(reset_n), .start_i(start && sel == 0), .vec_o(vec_a),
        .ref_i(ref_a), .dut_i(dut_a), .busy_o(busy_a), .done_o(done_a), .pass_o(pass_a),
        .mismatch_cnt_o(cnt_a), .first_fail_vec_o(ffv_a), .first_fail_vld_o(vld_a));
    truth_table_sweeper #(.N_IN(3), .N_OUT(1), .SETTLE(1), .CNT_W(2)) u_b (
        .clk_i(clk), .reset_n_i(reset_n), .start_i(start && sel == 1), .vec_o(vec_b),
        .ref_i(ref_b), .dut_i(dut_b), .busy_o(busy_b), .done_o(done_b), .pass_o(pass_b),
        .mismatch_cnt_o(cnt_b), .first_fail_vec_o(ffv_b), .first_fail_vld_o(vld_b));
    truth_table_sweeper #(.N_IN(2), .N_OUT(1), .SETTLE(0), .CNT_W(8)) u_c (
        .clk_i(clk), .reset_n_i(reset_n), .start_i(start && sel == 2), .vec_o(vec_c),
        .ref_i(ref_c), .dut_i(dut_c), .busy_o(busy_c), .done_o(done_c), .pass_o(pass_c),
        .mismatch_cnt_o(cnt_c), .first_fail_vec_o(ffv_c), .first_fail_vld_o(vld_c));
    always_comb begin
        vec_m  = sel == 0 ? 32'(vec_a) : sel == 1 ? 32'(vec_b) : 32'(vec_c);
        ffv_m  = sel == 0 ? 32'(ffv_a) : sel == 1 ? 32'(ffv_b) : 32'(ffv_c);
        cnt_m  = sel == 0 ? 32'(cnt_a) : sel == 1 ? 32'(cnt_b) : 32'(cnt_c);
        busy_m = sel == 0 ? busy_a : sel == 1 ? busy_b : busy_c;
        done_m = sel == 0 ? done_a : sel == 1 ? done_b : done_c;
        pass_m = sel == 0 ? pass_a : sel == 1 ? pass_b : pass_c;
        vld_m  = sel == 0 ? vld_a : sel == 1 ? vld_b : vld_c;
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    // Start a sweep on the selected instance; a start pulse is re-issued at cycle g (ignored while busy).
    task automatic sweep(input int g);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check("busy_after_start", 32'(busy_m), 1);
        check("done_after_start", 32'(done_m), 0);
        check("cnt_after_start", cnt_m, 0);
        check("vld_after_start", 32'(vld_m), 0);
        lat = 0;
        while (!done_m && lat < 200) begin
            if (sel == 2) check("t4_vec_step", vec_m, 32'(lat));
            start = (lat == g);
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
    endtask
    task automatic expect_result(input string t, input int l, input int c, input int fv, input int v, input int p, input int lastv);
        check({t, "_latency"}, 32'(lat), 32'(l));
        check({t, "_cnt"}, cnt_m, 32'(c));
        check({t, "_ffv"}, ffv_m, 32'(fv));
        check({t, "_vld"}, 32'(vld_m), 32'(v));
        check({t, "_pass"}, 32'(pass_m), 32'(p));
        check({t, "_vec"}, vec_m, 32'(lastv));
        check({t, "_busy"}, 32'(busy_m), 0);
    endtask
    initial begin
        #1;
        check("rst_vec", 32'(vec_a), 0);
        check("rst_busy", 32'(busy_a), 0);
        check("rst_done", 32'(done_a), 0);
        check("rst_cnt", 32'(cnt_a), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        sel = 0; mode = 0;
        sweep(-1);
        expect_result("t1", 8, 0, 0, 0, 1, 3);
        mode = 1;
        sweep(-1);
        expect_result("t2", 8, 2, 1, 1, 0, 2'b11);
        mode = 0;
        sweep(3);
        expect_result("t6", 8, 0, 0, 0, 1, 3);
        sel = 1;
        sweep(-1);
        expect_result("t3", 16, 3, 0, 1, 0, 7);
        sel = 2;
        sweep(-1);
        expect_result("t4", 4, 0, 0, 0, 1, 3);
        sel = 0; mode = 1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (4) @(negedge clk);
        check("t5_vec_before", 32'(vec_a), 2);
        #2 reset_n = 1'b0;
        #1;
        check("t5_vec", 32'(vec_a), 0);
        check("t5_busy", 32'(busy_a), 0);
        check("t5_done", 32'(done_a), 0);
        check("t5_pass", 32'(pass_a), 0);
        check("t5_cnt", 32'(cnt_a), 0);
        check("t5_ffv", 32'(ffv_a), 0);
        check("t5_vld", 32'(vld_a), 0);
        @(negedge clk) reset_n = 1'b1;
        sweep(-1);
        expect_result("t5_rerun", 8, 2, 1, 1, 0, 3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
